// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: registered read data and occupancy-decoded status flags.
// Also provides sticky overflow/underflow flags and a synchronous flush (clr).
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 64,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          buf_in,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          buf_out,
   output logic                       rd_valid,
   output logic                       buf_empty,
   output logic                       buf_full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     fifo_counter,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] buf_out_q, buf_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              wr_accept, rd_accept;

   // Status flags come straight from the registered occupancy.
   assign buf_empty    = (count_q == '0);
   assign buf_full     = (count_q == FULL_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign almost_full  = (count_q >= AF_CNT);
   assign fifo_counter = count_q;
   assign buf_out      = buf_out_q;
   assign rd_valid     = rd_valid_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_accept = wr_en & ~buf_full & ~clr;
   assign rd_accept = rd_en & ~buf_empty & ~clr;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      buf_out_d   = buf_out_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            buf_out_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
         end
         // A simultaneous accepted read and write leaves occupancy unchanged.
         case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (wr_en & buf_full)  overflow_d  = 1'b1;
         if (rd_en & buf_empty) underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         buf_out_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         buf_out_q   <= buf_out_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr_q] <= buf_in;
   end

endmodule
